uart_icb_regs: RTL and testbench
================================

# uart_icb_regs

ICB slave register block for the UART. It decodes single-beat ICB read/write commands into the CSR, CTRL and DATA registers and drives the baud divisor and control fields to the UART core. It turns the core's done/error pulses into sticky status flags and a level interrupt. It sits between the system ICB bus and the UART TX/RX engines, inside the UART top.

## Interface
Parameters:
- AW, 32: ICB address width.
- CSR_OFS, 8'h00: CSR offset, decoded on addr[7:0].
- CTRL_OFS, 8'h04: CTRL offset.
- DATA_OFS, 8'h08: DATA offset.

Ports (reset rst_n, asynchronous, active-low; clock clk):
- clk, in, 1: clock.
- rst_n, in, 1: async active-low reset.
- i_icb_cmd_valid / i_icb_cmd_ready, in / out, 1: command handshake.
- i_icb_cmd_addr, in, AW: byte address; only [7:0] decoded.
- i_icb_cmd_read, in, 1: 1 = read, 0 = write.
- i_icb_cmd_wdata, in, 32: write data.
- i_icb_rsp_valid / i_icb_rsp_ready, out / in, 1: response handshake.
- i_icb_rsp_rdata, out, 32: read data; 0 for writes.
- baud_div, out, 16: CSR[31:16].
- ctrl, out, 20: CTRL[19:0]. Fields: BAUD_EN[3:0], TX_EN[7:4], RX_EN[8], UART_EN[11:9], NO_PARITY[15:12], EV_PARITY[19:16].
- tx_data, out, 8: byte to send.
- tx_start, out, 1: one-cycle pulse on an accepted DATA write.
- tx_busy, in, 1: TX engine busy.
- tx_done, in, 1: pulse; frame sent.
- rx_done, in, 1: pulse; rx_byte valid.
- rx_byte, in, 8: received byte.
- parity_err, in, 1: qualified by rx_done.
- irq, out, 1: interrupt.

## Operation
- CSR bit map:
  - [0] tx_ok: sticky, set by tx_done.
  - [1] tx_ovr: DATA write while tx_busy.
  - [4] rx_ok: sticky, set by rx_done.
  - [5] rx_ovr: rx_done while rx_ok=1.
  - [6] par_err: rx_done & parity_err.
  - [8] tx_ie, [9] rx_ie: writable.
  - [31:16] baud_div: writable.
  - All other bits read 0.
- CSR write updates only [31:16] and [9:8]; status bits ignore writes.
- CSR read returns the current value, then clears [6:4] and [1:0] (read-to-clear) in the accept cycle.
- If a set event and a read-clear occur in the same cycle, set wins: the flag reads 1 next time.
- CTRL write loads wdata[19:0]; reads return {12'h0, ctrl}.
- DATA write, tx_busy=0: load tx_data = wdata[7:0] and pulse tx_start.
- DATA write, tx_busy=1: drop the data, no tx_start, set tx_ovr.
- DATA read returns {24'h0, rx_buf}. rx_buf loads rx_byte on every rx_done; on overrun the newer byte overwrites.
- Unmapped address: writes are ignored, reads return 0. Every command still gets a response.
- irq = (tx_ok & tx_ie) | (rx_ok & rx_ie), registered.

## Timing
- One outstanding transaction. i_icb_cmd_ready = !rsp_valid | i_icb_rsp_ready.
- Accept = cmd_valid & cmd_ready.
- rsp_valid rises the cycle after accept. rsp_valid and rdata stay stable until rsp_ready. Back-to-back accepts are possible when rsp_ready=1.
- Register writes and tx_start take effect in the accept cycle; tx_start is high the cycle after accept.
- Flag set: the cycle after the tx_done/rx_done pulse. irq follows one cycle later.
- Reset values: all registers 0, rsp_valid=0, rdata=0, tx_start=0, irq=0, cmd_ready=1.
- Reset mid-transaction drops the pending response.

## Test plan
- Write CSR 32'h0008_0300, then read CSR → rdata 32'h0008_0300; baud_div=16'h0008, tx_ie=rx_ie=1.
- Write CTRL 32'hF_1234 → ctrl=20'hF1234; read → 32'h000F_1234. Write 0x10 then read 0x10 → rdata 0.
- DATA write 8'hA5 with tx_busy=0 → tx_start one cycle, tx_data=8'hA5. Then tx_done pulse → irq=1; CSR[0]=1 on the first read, 0 on the second.
- DATA write with tx_busy=1 → no tx_start, tx_data unchanged, CSR[1]=1.
- rx_done with rx_byte 8'h3C, then rx_done with 8'hC3 and parity_err=1 before any read → CSR reads 32'h..._0070 (rx_ok, rx_ovr, par_err); DATA reads 32'hC3.
- Hold rsp_ready=0 for 5 cycles → rsp_valid and rdata stable, cmd_ready=0. tx_done in the same cycle as a CSR read → the next CSR read shows tx_ok=1.

Source files
------------

// File: rtl/uart_icb_regs.sv
// ICB slave register block for the UART: CSR/CTRL/DATA decode, sticky status
// flags built from the core's done/error pulses, and a registered level interrupt.
module uart_icb_regs #(
    parameter int unsigned AW       = 32,
    parameter logic [7:0]  CSR_OFS  = 8'h00,
    parameter logic [7:0]  CTRL_OFS = 8'h04,
    parameter logic [7:0]  DATA_OFS = 8'h08
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_icb_cmd_valid,
    output logic          i_icb_cmd_ready,
    input  logic [AW-1:0] i_icb_cmd_addr,
    input  logic          i_icb_cmd_read,
    input  logic [31:0]   i_icb_cmd_wdata,
    output logic          i_icb_rsp_valid,
    input  logic          i_icb_rsp_ready,
    output logic [31:0]   i_icb_rsp_rdata,
    output logic [15:0]   baud_div,
    output logic [19:0]   ctrl,
    output logic [7:0]    tx_data,
    output logic          tx_start,
    input  logic          tx_busy,
    input  logic          tx_done,
    input  logic          rx_done,
    input  logic [7:0]    rx_byte,
    input  logic          parity_err,
    output logic          irq
);

    logic        rsp_valid_q;
    logic [31:0] rdata_q;
    logic [15:0] baud_div_q;
    logic [19:0] ctrl_q;
    logic [7:0]  tx_data_q;
    logic        tx_start_q;
    logic [7:0]  rx_buf_q;
    logic        tx_ie_q, rx_ie_q;
    logic        tx_ok_q, tx_ovr_q, rx_ok_q, rx_ovr_q, par_err_q;
    logic        irq_q;

    logic        tx_ok_d, tx_ovr_d, rx_ok_d, rx_ovr_d, par_err_d;
    logic        accept, wr_en, rd_en;
    logic        sel_csr, sel_ctrl, sel_data;
    logic        csr_rd_clr, data_wr, tx_ovr_set;
    logic [31:0] csr_val;
    logic [31:0] rd_mux;
    logic        unused_addr;

    assign unused_addr = ^i_icb_cmd_addr[AW-1:8];

    assign i_icb_cmd_ready = ~rsp_valid_q | i_icb_rsp_ready;
    assign accept          = i_icb_cmd_valid & i_icb_cmd_ready;
    assign wr_en           = accept & ~i_icb_cmd_read;
    assign rd_en           = accept & i_icb_cmd_read;

    assign sel_csr  = (i_icb_cmd_addr[7:0] == CSR_OFS);
    assign sel_ctrl = (i_icb_cmd_addr[7:0] == CTRL_OFS);
    assign sel_data = (i_icb_cmd_addr[7:0] == DATA_OFS);

    assign csr_rd_clr = rd_en & sel_csr;
    assign data_wr    = wr_en & sel_data;
    assign tx_ovr_set = data_wr & tx_busy;

    assign csr_val = {baud_div_q, 6'b0, rx_ie_q, tx_ie_q, 1'b0,
                      par_err_q, rx_ovr_q, rx_ok_q, 2'b0, tx_ovr_q, tx_ok_q};

    always_comb begin
        rd_mux = 32'h0;
        if (i_icb_cmd_read) begin
            if (sel_csr) begin
                rd_mux = csr_val;
            end else if (sel_ctrl) begin
                rd_mux = {12'h0, ctrl_q};
            end else if (sel_data) begin
                rd_mux = {24'h0, rx_buf_q};
            end
        end
    end

    // Set events take priority over the read-to-clear of the same cycle.
    always_comb begin
        tx_ok_d   = tx_ok_q;
        tx_ovr_d  = tx_ovr_q;
        rx_ok_d   = rx_ok_q;
        rx_ovr_d  = rx_ovr_q;
        par_err_d = par_err_q;
        if (csr_rd_clr) begin
            tx_ok_d   = 1'b0;
            tx_ovr_d  = 1'b0;
            rx_ok_d   = 1'b0;
            rx_ovr_d  = 1'b0;
            par_err_d = 1'b0;
        end
        if (tx_done) begin
            tx_ok_d = 1'b1;
        end
        if (tx_ovr_set) begin
            tx_ovr_d = 1'b1;
        end
        if (rx_done) begin
            rx_ok_d = 1'b1;
            if (rx_ok_q) begin
                rx_ovr_d = 1'b1;
            end
            if (parity_err) begin
                par_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rdata_q     <= 32'h0;
        end else if (accept) begin
            rsp_valid_q <= 1'b1;
            rdata_q     <= rd_mux;
        end else if (i_icb_rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_div_q <= 16'h0;
            tx_ie_q    <= 1'b0;
            rx_ie_q    <= 1'b0;
            ctrl_q     <= 20'h0;
            tx_data_q  <= 8'h0;
            tx_start_q <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            if (wr_en && sel_csr) begin
                baud_div_q <= i_icb_cmd_wdata[31:16];
                rx_ie_q    <= i_icb_cmd_wdata[9];
                tx_ie_q    <= i_icb_cmd_wdata[8];
            end
            if (wr_en && sel_ctrl) begin
                ctrl_q <= i_icb_cmd_wdata[19:0];
            end
            // A DATA write while the transmitter is busy is dropped.
            if (data_wr && !tx_busy) begin
                tx_data_q  <= i_icb_cmd_wdata[7:0];
                tx_start_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_ok_q   <= 1'b0;
            tx_ovr_q  <= 1'b0;
            rx_ok_q   <= 1'b0;
            rx_ovr_q  <= 1'b0;
            par_err_q <= 1'b0;
            rx_buf_q  <= 8'h0;
            irq_q     <= 1'b0;
        end else begin
            tx_ok_q   <= tx_ok_d;
            tx_ovr_q  <= tx_ovr_d;
            rx_ok_q   <= rx_ok_d;
            rx_ovr_q  <= rx_ovr_d;
            par_err_q <= par_err_d;
            if (rx_done) begin
                rx_buf_q <= rx_byte;
            end
            irq_q <= (tx_ok_q & tx_ie_q) | (rx_ok_q & rx_ie_q);
        end
    end

    assign i_icb_rsp_valid = rsp_valid_q;
    assign i_icb_rsp_rdata = rdata_q;
    assign baud_div        = baud_div_q;
    assign ctrl            = ctrl_q;
    assign tx_data         = tx_data_q;
    assign tx_start        = tx_start_q;
    assign irq             = irq_q;

endmodule

// File: tb/tb_uart_icb_regs.sv
// Directed bench for uart_icb_regs: inputs change and outputs are sampled on the
// falling clock edge, so the rising edge always sees settled values.
module tb_uart_icb_regs;

    localparam logic [31:0] CSR  = 32'h00;
    localparam logic [31:0] CTRL = 32'h04;
    localparam logic [31:0] DATA = 32'h08;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_read;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [15:0] baud_div;
    logic [19:0] ctrl;
    logic [7:0]  tx_data;
    logic        tx_start, tx_busy, tx_done, rx_done, parity_err, irq;
    logic [7:0]  rx_byte;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    uart_icb_regs #(.AW(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_icb_cmd_valid (cmd_valid),
        .i_icb_cmd_ready (cmd_ready),
        .i_icb_cmd_addr  (cmd_addr),
        .i_icb_cmd_read  (cmd_read),
        .i_icb_cmd_wdata (cmd_wdata),
        .i_icb_rsp_valid (rsp_valid),
        .i_icb_rsp_ready (rsp_ready),
        .i_icb_rsp_rdata (rsp_rdata),
        .baud_div        (baud_div),
        .ctrl            (ctrl),
        .tx_data         (tx_data),
        .tx_start        (tx_start),
        .tx_busy         (tx_busy),
        .tx_done         (tx_done),
        .rx_done         (rx_done),
        .rx_byte         (rx_byte),
        .parity_err      (parity_err),
        .irq             (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Entered and left on a falling edge; waits (bounded) for cmd_ready first.
    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
    endtask

    task automatic icb_write(input logic [31:0] addr, input logic [31:0] data,
                             output logic [31:0] rdata, output logic start);
        rsp_ready = 1'b1;
        wait_ready();
        cmd_valid = 1'b1;
        cmd_read  = 1'b0;
        cmd_addr  = addr;
        cmd_wdata = data;
        @(negedge clk);
        cmd_valid = 1'b0;
        rdata     = rsp_valid ? rsp_rdata : 32'hDEAD_BEEF;
        start     = tx_start;
    endtask

    task automatic icb_read(input logic [31:0] addr, output logic [31:0] rdata);
        rsp_ready = 1'b1;
        wait_ready();
        cmd_valid = 1'b1;
        cmd_read  = 1'b1;
        cmd_addr  = addr;
        @(negedge clk);
        cmd_valid = 1'b0;
        rdata     = rsp_valid ? rsp_rdata : 32'hDEAD_BEEF;
    endtask

    initial begin
        logic [31:0] rd, held;
        logic        st;

        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_read = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b1; tx_busy = 1'b0; tx_done = 1'b0; rx_done = 1'b0;
        rx_byte = 8'h0; parity_err = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_irq_start", {30'b0, irq, tx_start}, 32'h0);
        check("rst_baud_ctrl", {baud_div, 12'b0, ctrl[3:0]}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        icb_write(CSR, 32'h0008_0300, rd, st);
        check("csr_wr_rdata", rd, 32'h0);
        icb_read(CSR, rd);
        check("csr_rd", rd, 32'h0008_0300);
        check("baud_div", 32'(baud_div), 32'h0008);

        icb_write(CTRL, 32'h000F_1234, rd, st);
        check("ctrl_out", 32'(ctrl), 32'h000F_1234);
        icb_read(CTRL, rd);
        check("ctrl_rd", rd, 32'h000F_1234);
        icb_write(32'h10, 32'hFFFF_FFFF, rd, st);
        icb_read(32'h10, rd);
        check("unmapped_rd", rd, 32'h0);
        icb_read(CTRL, rd);
        check("ctrl_after_unmapped", rd, 32'h000F_1234);

        icb_write(DATA, 32'h0000_00A5, rd, st);
        check("tx_start_pulse", 32'(st), 32'd1);
        check("tx_data", 32'(tx_data), 32'hA5);
        @(negedge clk);
        check("tx_start_one_cycle", 32'(tx_start), 32'd0);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("irq_lags_flag", 32'(irq), 32'd0);
        @(negedge clk);
        check("irq_tx", 32'(irq), 32'd1);
        icb_read(CSR, rd);
        check("csr_tx_ok_first", rd, 32'h0008_0301);
        icb_read(CSR, rd);
        check("csr_tx_ok_cleared", rd, 32'h0008_0300);
        repeat (2) @(negedge clk);
        check("irq_cleared", 32'(irq), 32'd0);

        tx_busy = 1'b1;
        icb_write(DATA, 32'h0000_005A, rd, st);
        check("busy_no_start", 32'(st), 32'd0);
        check("busy_tx_data", 32'(tx_data), 32'hA5);
        tx_busy = 1'b0;
        icb_read(CSR, rd);
        check("csr_tx_ovr", rd, 32'h0008_0302);

        rx_done = 1'b1; rx_byte = 8'h3C;
        @(negedge clk);
        rx_done = 1'b0;
        @(negedge clk);
        rx_done = 1'b1; rx_byte = 8'hC3; parity_err = 1'b1;
        @(negedge clk);
        rx_done = 1'b0; parity_err = 1'b0;
        icb_read(CSR, rd);
        check("csr_rx_flags", rd, 32'h0008_0370);
        icb_read(DATA, rd);
        check("data_rx_overwrite", rd, 32'h0000_00C3);
        icb_read(CSR, rd);
        check("csr_rx_cleared", rd, 32'h0008_0300);

        // Stalled response must hold steady and block new commands.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = CTRL; rsp_ready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        held = rsp_rdata;
        check("stall_rdata", held, 32'h000F_1234);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid_ready", {30'b0, rsp_valid, cmd_ready}, 32'h2);
            check("stall_rdata_stable", rsp_rdata, held);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("stall_released", 32'(rsp_valid), 32'd0);

        cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = CSR; tx_done = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0; tx_done = 1'b0;
        check("race_rd_old", rsp_rdata, 32'h0008_0300);
        icb_read(CSR, rd);
        check("race_set_wins", rd, 32'h0008_0301);

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_drops_rsp", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
